// File: rtl/spell_mem_arbiter_if.sv
// Bundles the core/debug requester ports and the memory port of spell_mem_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface spell_mem_arbiter_if;
    logic       c_req;
    logic       c_write;
    logic       c_type_data;
    logic [7:0] c_addr;
    logic [7:0] c_wdata;
    logic       c_ack;
    logic [7:0] c_rdata;

    logic       d_req;
    logic       d_write;
    logic       d_type_data;
    logic [7:0] d_addr;
    logic [7:0] d_wdata;
    logic       d_ack;
    logic [7:0] d_rdata;

    logic       m_select;
    logic       m_write;
    logic       m_type_data;
    logic [7:0] m_addr;
    logic [7:0] m_wdata;
    logic [7:0] m_rdata;
    logic       m_ready;

    logic       err;

    modport slave (
        input  c_req, c_write, c_type_data, c_addr, c_wdata,
        output c_ack, c_rdata,
        input  d_req, d_write, d_type_data, d_addr, d_wdata,
        output d_ack, d_rdata,
        output m_select, m_write, m_type_data, m_addr, m_wdata,
        input  m_rdata, m_ready,
        output err
    );

    modport master (
        output c_req, c_write, c_type_data, c_addr, c_wdata,
        input  c_ack, c_rdata,
        output d_req, d_write, d_type_data, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  m_select, m_write, m_type_data, m_addr, m_wdata,
        output m_rdata, m_ready,
        input  err
    );
endinterface

// File: rtl/spell_mem_arbiter.sv
// Round-robin arbiter of a core and a debug/loader requester onto one memory port.
// Define SPELL_ARB_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES with rdata 8'hFF and sticky err.
module spell_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic                clk,
    input logic                rst,
    spell_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_e;

    state_e     state_q, state_d;
    logic       last_dbg_q, last_dbg_d;
    logic       owner_dbg_q, owner_dbg_d;
    logic       sel_q, sel_d;
    logic       write_q, write_d;
    logic       type_q, type_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       c_ack_q, c_ack_d;
    logic       d_ack_q, d_ack_d;
    logic [7:0] c_rdata_q, c_rdata_d;
    logic [7:0] d_rdata_q, d_rdata_d;

    logic       grant_dbg;
    logic       done;
    logic       done_load;
    logic [7:0] done_rdata;

`ifdef SPELL_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // On a tie the requester that was not granted last wins.
    assign grant_dbg = bus.d_req & (~bus.c_req | ~last_dbg_q);

    always_comb begin
        state_d     = state_q;
        last_dbg_d  = last_dbg_q;
        owner_dbg_d = owner_dbg_q;
        sel_d       = sel_q;
        write_d     = write_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        c_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        c_rdata_d   = c_rdata_q;
        d_rdata_d   = d_rdata_q;
        done        = 1'b0;
        done_load   = 1'b0;
        done_rdata  = bus.m_rdata;
`ifdef SPELL_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (bus.c_req || bus.d_req) begin
                    state_d     = StAccess;
                    owner_dbg_d = grant_dbg;
                    last_dbg_d  = grant_dbg;
                    sel_d       = 1'b1;
                    write_d     = grant_dbg ? bus.d_write     : bus.c_write;
                    type_d      = grant_dbg ? bus.d_type_data : bus.c_type_data;
                    addr_d      = grant_dbg ? bus.d_addr      : bus.c_addr;
                    wdata_d     = grant_dbg ? bus.d_wdata     : bus.c_wdata;
`ifdef SPELL_ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StAccess: begin
                if (bus.m_ready) begin
                    done      = 1'b1;
                    done_load = ~write_q;
                end
`ifdef SPELL_ARB_TIMEOUT_EN
                else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    done       = 1'b1;
                    done_load  = 1'b1;
                    done_rdata = 8'hFF;
                    err_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`endif
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Completion: drop select for the release cycle and pulse the owner's ack.
        if (done) begin
            state_d = StRelease;
            sel_d   = 1'b0;
            if (owner_dbg_q) begin
                d_ack_d = 1'b1;
                if (done_load) d_rdata_d = done_rdata;
            end else begin
                c_ack_d = 1'b1;
                if (done_load) c_rdata_d = done_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_dbg_q  <= 1'b1;
            owner_dbg_q <= 1'b0;
            sel_q       <= 1'b0;
            write_q     <= 1'b0;
            type_q      <= 1'b0;
            addr_q      <= 8'h00;
            wdata_q     <= 8'h00;
            c_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            c_rdata_q   <= 8'h00;
            d_rdata_q   <= 8'h00;
        end else begin
            last_dbg_q  <= last_dbg_d;
            owner_dbg_q <= owner_dbg_d;
            sel_q       <= sel_d;
            write_q     <= write_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            c_ack_q     <= c_ack_d;
            d_ack_q     <= d_ack_d;
            c_rdata_q   <= c_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

`ifdef SPELL_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.m_select    = sel_q;
    assign bus.m_write     = write_q;
    assign bus.m_type_data = type_q;
    assign bus.m_addr      = addr_q;
    assign bus.m_wdata     = wdata_q;
    assign bus.c_ack       = c_ack_q;
    assign bus.d_ack       = d_ack_q;
    assign bus.c_rdata     = c_rdata_q;
    assign bus.d_rdata     = d_rdata_q;
endmodule

// File: tb/tb_spell_mem_arbiter.sv
// Bench for spell_mem_arbiter: requester agents, a latency-programmable memory responder and a
// transaction-level model checked every cycle, plus directed literal expectations.
module tb_spell_mem_arbiter;
    localparam int unsigned TO = 4;

    typedef struct packed {
        logic       write;
        logic       typ;
        logic [7:0] addr;
        logic [7:0] wdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    spell_mem_arbiter_if bus ();

    spell_mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   c_ack_cnt = 0;
    int   d_ack_cnt = 0;
    int   last_sel_len = 0;
    int   lat = 0;
    int   ack_log[$];
    txn_t c_q[$];
    txn_t d_q[$];
    logic [7:0] mem [256];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int log_code();
        int v = 0;
        foreach (ack_log[i]) v = v * 2 + ack_log[i];
        return v;
    endfunction

    // Core requester: holds req until its ack, then moves on the cycle after.
    logic c_acked = 1'b0;
    initial begin
        bus.c_req = 0; bus.c_write = 0; bus.c_type_data = 0; bus.c_addr = 0; bus.c_wdata = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.c_req = 0;
                c_acked = 0;
            end else begin
                if (c_acked) begin
                    c_acked = 0;
                    bus.c_req = 0;
                    if (c_q.size() > 0) void'(c_q.pop_front());
                end else if (bus.c_req && bus.c_ack) begin
                    c_acked = 1;
                end
                if (!bus.c_req && c_q.size() > 0) begin
                    bus.c_req = 1;
                    bus.c_write = c_q[0].write;
                    bus.c_type_data = c_q[0].typ;
                    bus.c_addr = c_q[0].addr;
                    bus.c_wdata = c_q[0].wdata;
                end
            end
        end
    end

    logic d_acked = 1'b0;
    initial begin
        bus.d_req = 0; bus.d_write = 0; bus.d_type_data = 0; bus.d_addr = 0; bus.d_wdata = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                bus.d_req = 0;
                d_acked = 0;
            end else begin
                if (d_acked) begin
                    d_acked = 0;
                    bus.d_req = 0;
                    if (d_q.size() > 0) void'(d_q.pop_front());
                end else if (bus.d_req && bus.d_ack) begin
                    d_acked = 1;
                end
                if (!bus.d_req && d_q.size() > 0) begin
                    bus.d_req = 1;
                    bus.d_write = d_q[0].write;
                    bus.d_type_data = d_q[0].typ;
                    bus.d_addr = d_q[0].addr;
                    bus.d_wdata = d_q[0].wdata;
                end
            end
        end
    end

    // Memory: ready after `lat` selected cycles; junk data and random ready when not selected.
    initial begin
        int sel_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h10] = 8'hA5; mem[8'h01] = 8'h11; mem[8'h02] = 8'h22;
        mem[8'h22] = 8'hC2; mem[8'h2A] = 8'hDA; mem[8'h41] = 8'h77;
        mem[8'h50] = 8'h55; mem[8'h51] = 8'h66;
        bus.m_ready = 0;
        bus.m_rdata = 0;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = 0;
            bus.m_rdata = 8'($urandom);
            if (rst || !bus.m_select) begin
                sel_cnt = 0;
                bus.m_ready = 1'($urandom_range(0, 1));
            end else begin
                if (sel_cnt >= lat) begin
                    bus.m_ready = 1;
                    bus.m_rdata = mem[bus.m_addr];
                end
                sel_cnt++;
            end
        end
    end

    // Transaction-level model, compared on every falling edge.
    initial begin
        logic sel_prev, prev_idle, pend_ack, pend_dbg, pend_to, owner_dbg, last_dbg, model_err;
        logic win_dbg, exp_sel, new_pend, new_to;
        logic [7:0] mdl_c_rdata, mdl_d_rdata, pend_rdata, new_rdata;
        logic prev_c_req, prev_d_req;
        txn_t prev_c, prev_d, cur;
        int sel_len;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_m_select", bus.m_select, 0);
                chk("rst_c_ack", bus.c_ack, 0);
                chk("rst_d_ack", bus.d_ack, 0);
                chk("rst_err", bus.err, 0);
                sel_prev = 0; prev_idle = 1; pend_ack = 0; pend_dbg = 0; pend_to = 0;
                owner_dbg = 0; last_dbg = 1; model_err = 0; mdl_c_rdata = 0; mdl_d_rdata = 0;
                pend_rdata = 0; prev_c_req = 0; prev_d_req = 0; prev_c = '0; prev_d = '0;
                cur = '0; sel_len = 0;
            end else begin
                exp_sel = sel_prev ? !pend_ack : (prev_idle && (prev_c_req || prev_d_req));
                chk("m_select", bus.m_select, exp_sel);
                chk("c_ack", bus.c_ack, pend_ack && !pend_dbg);
                chk("d_ack", bus.d_ack, pend_ack && pend_dbg);
                if (pend_ack) begin
                    if (pend_dbg) mdl_d_rdata = pend_rdata;
                    else mdl_c_rdata = pend_rdata;
                    if (pend_to) model_err = 1;
                end
                chk("c_rdata", bus.c_rdata, mdl_c_rdata);
                chk("d_rdata", bus.d_rdata, mdl_d_rdata);
                chk("err", bus.err, model_err);
                if (bus.c_ack) begin c_ack_cnt++; ack_log.push_back(0); end
                if (bus.d_ack) begin d_ack_cnt++; ack_log.push_back(1); end

                if (bus.m_select && !sel_prev) begin
                    win_dbg = prev_d_req && (!prev_c_req || !last_dbg);
                    last_dbg = win_dbg;
                    owner_dbg = win_dbg;
                    cur = win_dbg ? prev_d : prev_c;
                    sel_len = 0;
                end
                if (bus.m_select) begin
                    chk("m_write", bus.m_write, cur.write);
                    chk("m_type_data", bus.m_type_data, cur.typ);
                    chk("m_addr", bus.m_addr, cur.addr);
                    chk("m_wdata", bus.m_wdata, cur.wdata);
                    sel_len++;
                end else if (sel_prev) begin
                    last_sel_len = sel_len;
                end

                new_pend = 0; new_to = 0; new_rdata = 0;
                if (bus.m_select) begin
                    if (bus.m_ready) begin
                        new_pend = 1;
                        new_rdata = cur.write ? (owner_dbg ? mdl_d_rdata : mdl_c_rdata)
                                              : bus.m_rdata;
                    end
`ifdef SPELL_ARB_TIMEOUT_EN
                    else if (sel_len == TO) begin
                        new_pend = 1;
                        new_to = 1;
                        new_rdata = 8'hFF;
                    end
`endif
                end
                prev_idle = !bus.m_select && !pend_ack;
                pend_ack = new_pend;
                pend_dbg = owner_dbg;
                pend_to = new_to;
                pend_rdata = new_rdata;
                sel_prev = bus.m_select;
                prev_c_req = bus.c_req;
                prev_d_req = bus.d_req;
                prev_c = '{bus.c_write, bus.c_type_data, bus.c_addr, bus.c_wdata};
                prev_d = '{bus.d_write, bus.d_type_data, bus.d_addr, bus.d_wdata};
            end
        end
    end

    task automatic wait_acks(input int tc, input int td, input string name);
        int n = 0;
        while ((c_ack_cnt < tc || d_ack_cnt < td) && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk(name, (c_ack_cnt >= tc) && (d_ack_cnt >= td), 1);
        repeat (2) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst = 1;
        c_q.delete();
        d_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 0;
    endtask

    initial begin
        int cb, db, n;
        logic [7:0] d_keep;
        #1 rst = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_m_select", bus.m_select, 0);
        chk("reset_m_write", bus.m_write, 0);
        chk("reset_m_type", bus.m_type_data, 0);
        chk("reset_m_addr", bus.m_addr, 0);
        chk("reset_m_wdata", bus.m_wdata, 0);
        chk("reset_c_rdata", bus.c_rdata, 0);
        chk("reset_d_rdata", bus.d_rdata, 0);
        chk("reset_err", bus.err, 0);
        #1 rst = 0;

        // Single core read, memory ready in the first select cycle.
        cb = c_ack_cnt; db = d_ack_cnt;
        c_q.push_back('{1'b0, 1'b1, 8'h10, 8'h00});
        wait_acks(cb + 1, db, "t1_done");
        chk("t1_c_rdata", bus.c_rdata, 8'hA5);
        chk("t1_c_acks", c_ack_cnt - cb, 1);
        chk("t1_d_acks", d_ack_cnt - db, 0);
        chk("t1_sel_len", last_sel_len, 1);

        // Simultaneous requests after reset: core first, then debug.
        do_reset();
        ack_log.delete();
        cb = c_ack_cnt; db = d_ack_cnt;
        c_q.push_back('{1'b0, 1'b1, 8'h01, 8'h00});
        d_q.push_back('{1'b0, 1'b1, 8'h02, 8'h00});
        wait_acks(cb + 1, db + 1, "t2_done");
        chk("t2_order_len", ack_log.size(), 2);
        chk("t2_order", log_code(), 1);
        chk("t2_c_rdata", bus.c_rdata, 8'h11);
        chk("t2_d_rdata", bus.d_rdata, 8'h22);

        // Both held for six transactions: strict alternation.
        do_reset();
        ack_log.delete();
        cb = c_ack_cnt; db = d_ack_cnt;
        for (int i = 0; i < 3; i++) begin
            c_q.push_back('{1'b0, 1'b1, 8'(8'h20 + i), 8'h00});
            d_q.push_back('{1'b0, 1'b0, 8'(8'h28 + i), 8'h00});
        end
        wait_acks(cb + 3, db + 3, "t3_done");
        chk("t3_order_len", ack_log.size(), 6);
        chk("t3_order", log_code(), 6'b010101);
        chk("t3_c_rdata", bus.c_rdata, 8'hC2);
        chk("t3_d_rdata", bus.d_rdata, 8'hDA);

        // Debug write with delayed ready: four stable select cycles, rdata untouched.
        d_keep = bus.d_rdata;
        lat = 3;
        cb = c_ack_cnt; db = d_ack_cnt;
        d_q.push_back('{1'b1, 1'b1, 8'h30, 8'h5A});
        wait_acks(cb, db + 1, "t4_done");
        chk("t4_sel_len", last_sel_len, 4);
        chk("t4_d_acks", d_ack_cnt - db, 1);
        chk("t4_c_acks", c_ack_cnt - cb, 0);
        chk("t4_d_rdata", bus.d_rdata, d_keep);
        lat = 0;

        // Reset in the middle of an access.
        lat = 1000;
        cb = c_ack_cnt;
        c_q.push_back('{1'b0, 1'b1, 8'h40, 8'h00});
        n = 0;
        while (!bus.m_select && n < 20) begin @(posedge clk); #1; n++; end
        chk("t5_sel_seen", bus.m_select, 1);
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("t5_async_sel", bus.m_select, 0);
        chk("t5_async_cack", bus.c_ack, 0);
        c_q.delete();
        repeat (2) @(posedge clk);
        #2 rst = 0;
        lat = 0;
        repeat (3) @(posedge clk);
        chk("t5_no_ack", c_ack_cnt - cb, 0);
        c_q.push_back('{1'b0, 1'b1, 8'h41, 8'h00});
        wait_acks(cb + 1, d_ack_cnt, "t5_next_done");
        chk("t5_c_rdata", bus.c_rdata, 8'h77);

        // Memory that never answers.
        lat = 1000;
        cb = c_ack_cnt;
        c_q.push_back('{1'b0, 1'b1, 8'h50, 8'h00});
`ifdef SPELL_ARB_TIMEOUT_EN
        wait_acks(cb + 1, d_ack_cnt, "t6_to_done");
        chk("t6_to_rdata", bus.c_rdata, 8'hFF);
        chk("t6_to_err", bus.err, 1);
        chk("t6_to_sel_len", last_sel_len, TO);
        lat = 0;
        c_q.push_back('{1'b0, 1'b1, 8'h51, 8'h00});
        wait_acks(cb + 2, d_ack_cnt, "t6_after_done");
        chk("t6_err_sticky", bus.err, 1);
        chk("t6_after_rdata", bus.c_rdata, 8'h66);
        do_reset();
        #1;
        chk("t6_err_cleared", bus.err, 0);
`else
        repeat (30) @(posedge clk);
        #1;
        chk("t6_still_waiting", c_ack_cnt - cb, 0);
        chk("t6_sel_held", bus.m_select, 1);
        chk("t6_err_zero", bus.err, 0);
        lat = 0;
        wait_acks(cb + 1, d_ack_cnt, "t6_done");
        chk("t6_c_rdata", bus.c_rdata, 8'h55);
`endif

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
        $fatal(1, "watchdog expired");
    end
endmodule
